bus_master_ctrl: RTL and testbench
==================================

# bus_master_ctrl

Bus master interface controller that sits directly upstream of the bus arbiter, one instance per master port (m0–m3). It accepts single-word read/write requests from a core and raises the master's active-low bus request. It waits for the arbiter's grant, then drives one address-strobe transaction and holds ownership until the slave's ready or a timeout. It returns read data and a completion/error pulse to the core.

## Interface
- ADDR_W, 30, word-address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before error; 0 disables timeout; counter width 8
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (`RESET_EDGE`/`RESET_ENABLE` from stddef.vh)
- core_as_  in  1  active-low request strobe from core, sampled in IDLE only
- core_rw  in  1  READ=1, WRITE=0
- core_addr  in  ADDR_W  word address
- core_wr_data  in  DATA_W  write data
- core_flush  in  1  active-high abort, honoured in REQ only
- core_busy  out  1  high while state != IDLE
- core_done  out  1  one-cycle pulse on successful completion
- core_err  out  1  one-cycle pulse on timeout
- core_rd_data  out  DATA_W  read data, valid in the core_done cycle and held until the next completion
- bus_req_  out  1  active-low request to arbiter (mN_req_)
- bus_grnt_  in  1  active-low grant from arbiter (mN_grnt_)
- bus_as_  out  1  active-low address strobe
- bus_rw  out  1  READ=1, WRITE=0
- bus_addr  out  ADDR_W  address to bus
- bus_wr_data  out  DATA_W  write data to bus
- bus_rd_data  in  DATA_W  read data from slave mux
- bus_rdy_  in  1  active-low slave ready

## Operation
- States: IDLE, REQ, ACCESS, WAIT. Reset enters IDLE.
- IDLE:
  - core_as_ low → latch core_rw, core_addr and core_wr_data into bus_rw, bus_addr and bus_wr_data.
  - Drive bus_req_ low; go to REQ.
- REQ:
  - bus_grnt_ low → go to ACCESS.
  - Otherwise, core_flush high → release bus_req_ and go to IDLE with no pulse.
  - Flush has priority below grant: if grant and flush arrive in the same cycle, the transaction proceeds.
- ACCESS: bus_as_ low for exactly this one cycle; timeout counter cleared.
  - bus_rdy_ low → complete.
  - Otherwise go to WAIT.
- WAIT: bus_as_ high, bus_req_ still low so the arbiter keeps ownership.
  - bus_rdy_ low → complete.
  - Otherwise the counter increments. With TIMEOUT≠0, the cycle in which the counter equals TIMEOUT−1 with rdy_ still high is an error.
- Complete:
  - Read → register bus_rd_data into core_rd_data. Write → core_rd_data unchanged.
  - Pulse core_done and release bus_req_; go to IDLE.
- Error: pulse core_err, core_rd_data forced to 0, release bus_req_, go to IDLE.
- core_flush is ignored in ACCESS and WAIT; a started transaction always finishes or times out.
- core_as_ is ignored while busy; the core must hold off on core_busy.
- bus_addr, bus_rw and bus_wr_data are stable from REQ entry until return to IDLE.

## Timing
- Reset values:
  - bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0, bus_wr_data=0.
  - core_rd_data=0, core_done=0, core_err=0, core_busy=0.
- All outputs are registered.
- Minimum latency, core_as_ sample to core_done: 3 cycles. That is IDLE→REQ (req_ low), granted next edge, ACCESS with rdy_ low, done at the following edge.
- With the arbiter's one-cycle grant registration, bus_req_ low to bus_grnt_ low is at least 1 cycle.
- No new request is accepted in the cycle core_done or core_err is high; the earliest new sample is the next edge.
- Reset asserted mid-transaction → immediately IDLE with reset values; no pulse.

## Structure
- bus.vh holds:
  - BUS_IF_STATE_IDLE/REQ/ACCESS/WAIT as 2-bit encodings, and `BUS_IF_STATE_BUS`.
  - `READ`/`WRITE`.
  - `WORD_ADDR_W`/`WORD_DATA_W`.
- stddef.vh supplies ENABLE_/DISABLE_ and the reset macros.
- Single module; no sub-module is warranted. The timeout counter is one always block.

## Test plan
- Read, immediate grant and ready: core_as_ low, addr=0x0000010, slave returns 0xDEADBEEF with rdy_ low in ACCESS → bus_as_ low for 1 cycle, core_done at cycle 3, core_rd_data=0xDEADBEEF, bus_req_ high after.
- Write with 4 wait states: wr_data=0x12345678, rdy_ low on 4th WAIT cycle → bus_wr_data stable throughout, core_done once, core_rd_data unchanged.
- Grant delayed 5 cycles by another master: bus_req_ low for 5 cycles with bus_as_ high, then normal access.
- Flush in REQ at cycle 2 → bus_req_ high next cycle, IDLE, no done/err. Flush in WAIT → ignored, done still arrives.
- TIMEOUT=8, slave never ready → core_err pulses after 8 WAIT cycles, core_rd_data=0, bus_req_ released.
- Reset asserted during WAIT → all outputs at reset values asynchronously; a new read after release completes normally.

Source files
------------

// File: rtl/bus_master_ctrl_pkg.sv
// Shared types and constants for the bus master interface controller.
package bus_master_ctrl_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_REQ    = 2'b01,
      ST_ACCESS = 2'b10,
      ST_WAIT   = 2'b11
   } bus_if_state_t;

   // Bus direction encodings
   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   // Default word address / data widths
   localparam int WORD_ADDR_W = 30;
   localparam int WORD_DATA_W = 32;

   // Width of the WAIT-state timeout counter
   localparam int TMO_CNT_W = 8;

   // True in the WAIT cycle that exhausts the timeout budget; limit 0 never expires
   function automatic logic tmo_expired(input logic [TMO_CNT_W-1:0] cnt,
                                        input int unsigned         limit);
      return (limit != 0) && (cnt == TMO_CNT_W'(limit - 1));
   endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Master-side bus signals between one controller and the arbiter / slave mux.
interface bus_master_ctrl_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              bus_req_;
   logic              bus_grnt_;
   logic              bus_as_;
   logic              bus_rw;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wr_data;
   logic [DATA_W-1:0] bus_rd_data;
   logic              bus_rdy_;

   // Controller side
   modport master (
      output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
      input  bus_grnt_, bus_rd_data, bus_rdy_
   );

   // Arbiter / slave side
   modport slave (
      input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
      output bus_grnt_, bus_rd_data, bus_rdy_
   );
endinterface

// File: rtl/bus_master_ctrl.sv
// Bus master interface controller: turns single-word core requests into one
// arbitrated address-strobe transaction, with optional WAIT-state timeout.
module bus_master_ctrl
   import bus_master_ctrl_pkg::*;
#(
   parameter int          ADDR_W  = WORD_ADDR_W,
   parameter int          DATA_W  = WORD_DATA_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_as_,
   input  logic              core_rw,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wr_data,
   input  logic              core_flush,
   output logic              core_busy,
   output logic              core_done,
   output logic              core_err,
   output logic [DATA_W-1:0] core_rd_data,
   bus_master_ctrl_if.master bus
);

   bus_if_state_t          state;
   logic [TMO_CNT_W-1:0]   tmo_cnt;
   logic                   tmo_hit;

   // Timeout condition for the current WAIT cycle
   always_comb begin
      tmo_hit = tmo_expired(tmo_cnt, TIMEOUT);
   end

   // WAIT-state counter: cleared in ACCESS, counts each WAIT cycle without ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (state == ST_ACCESS) begin
         tmo_cnt <= '0;
      end else if (state == ST_WAIT && bus.bus_rdy_) begin
         tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
      end
   end

   // Transaction FSM with registered core and bus outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ST_IDLE;
         core_busy       <= 1'b0;
         core_done       <= 1'b0;
         core_err        <= 1'b0;
         core_rd_data    <= '0;
         bus.bus_req_    <= 1'b1;
         bus.bus_as_     <= 1'b1;
         bus.bus_rw      <= READ;
         bus.bus_addr    <= '0;
         bus.bus_wr_data <= '0;
      end else begin
         core_done <= 1'b0;
         core_err  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               // A completion pulse cycle never accepts a new request
               if (!core_as_ && !core_done && !core_err) begin
                  bus.bus_rw      <= core_rw;
                  bus.bus_addr    <= core_addr;
                  bus.bus_wr_data <= core_wr_data;
                  bus.bus_req_    <= 1'b0;
                  core_busy       <= 1'b1;
                  state           <= ST_REQ;
               end
            end
            ST_REQ: begin
               // Grant outranks a same-cycle flush
               if (!bus.bus_grnt_) begin
                  bus.bus_as_ <= 1'b0;
                  state       <= ST_ACCESS;
               end else if (core_flush) begin
                  bus.bus_req_ <= 1'b1;
                  core_busy    <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            ST_ACCESS, ST_WAIT: begin
               // ACCESS and WAIT share completion; only WAIT can time out
               bus.bus_as_ <= 1'b1;
               if (!bus.bus_rdy_) begin
                  if (bus.bus_rw != WRITE) begin
                     core_rd_data <= bus.bus_rd_data;
                  end
                  core_done    <= 1'b1;
                  core_busy    <= 1'b0;
                  bus.bus_req_ <= 1'b1;
                  state        <= ST_IDLE;
               end else if (state == ST_WAIT && tmo_hit) begin
                  core_rd_data <= '0;
                  core_err     <= 1'b1;
                  core_busy    <= 1'b0;
                  bus.bus_req_ <= 1'b1;
                  state        <= ST_IDLE;
               end else begin
                  state <= ST_WAIT;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Randomized self-checking bench for bus_master_ctrl; the bench plays core,
// arbiter and slave, and predicts each transaction's timeline from its
// grant delay, wait-state count and flush point.
module tb_bus_master_ctrl;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_as_ = 1'b1;
   logic        core_rw = 1'b1;
   logic [29:0] core_addr = '0;
   logic [31:0] core_wr_data = '0;
   logic        core_flush = 1'b0;
   logic        core_busy;
   logic        core_done;
   logic        core_err;
   logic [31:0] core_rd_data;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_rd = '0;

   bus_master_ctrl_if #(.ADDR_W(30), .DATA_W(32)) bif ();

   bus_master_ctrl #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .core_as_     (core_as_),
      .core_rw      (core_rw),
      .core_addr    (core_addr),
      .core_wr_data (core_wr_data),
      .core_flush   (core_flush),
      .core_busy    (core_busy),
      .core_done    (core_done),
      .core_err     (core_err),
      .core_rd_data (core_rd_data),
      .bus          (bif.master)
   );

   always #5 clk = ~clk;

   initial begin
      bif.bus_grnt_    = 1'b1;
      bif.bus_rdy_     = 1'b1;
      bif.bus_rd_data  = '0;
   end

   // One transaction. Edge 0 samples core_as_; grant is seen at edge g+1;
   // ready is seen at edge g+2+w. Flush is held from edge fe on (0 = none).
   // hold_next keeps core_as_ low through the completion pulse cycle.
   task automatic run_txn(input logic rw, input logic [29:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int g, input int w, input int fe,
                          input bit hold_next);
      int end_k;
      bit ok, er;
      logic [4:0] exp_ctl, got_ctl;
      if (fe >= 1 && fe <= g) begin
         end_k = fe; ok = 1'b0; er = 1'b0;
      end else if (w > TMO) begin
         end_k = g + 2 + TMO; ok = 1'b0; er = 1'b1;
      end else begin
         end_k = g + 2 + w; ok = 1'b1; er = 1'b0;
      end
      core_rw = rw; core_addr = a; core_wr_data = wd;
      core_as_ = 1'b0; core_flush = 1'b0;
      bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1;
      bif.bus_rd_data = $urandom;
      for (int k = 0; k <= end_k + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == end_k) begin
            if (ok && rw == 1'b1) exp_rd = rd;
            if (er) exp_rd = '0;
         end
         exp_ctl = {k < end_k, !(k < end_k), !(k == g + 1 && k < end_k),
                    k == end_k && ok, k == end_k && er};
         got_ctl = {core_busy, bif.bus_req_, bif.bus_as_, core_done, core_err};
         n_checks++;
         if (got_ctl !== exp_ctl) begin
            n_errors++;
            $display("FAIL ctl k=%0d {busy,req_,as_,done,err} got %b expected %b",
                     k, got_ctl, exp_ctl);
         end
         n_checks++;
         if (core_rd_data !== exp_rd) begin
            n_errors++;
            $display("FAIL rd_data k=%0d got %h expected %h", k, core_rd_data, exp_rd);
         end
         if (k < end_k) begin
            n_checks++;
            if ({bif.bus_rw, bif.bus_addr, bif.bus_wr_data} !== {rw, a, wd}) begin
               n_errors++;
               $display("FAIL bus_hold k=%0d got rw=%b addr=%h wd=%h expected rw=%b addr=%h wd=%h",
                        k, bif.bus_rw, bif.bus_addr, bif.bus_wr_data, rw, a, wd);
            end
         end
         if (k == 0) begin
            core_rw = 1'($urandom); core_addr = 30'($urandom); core_wr_data = $urandom;
         end
         core_as_      = (hold_next && k >= end_k) ? 1'b0 : 1'b1;
         core_flush    = (fe != 0 && k + 1 >= fe && k + 1 <= end_k);
         bif.bus_grnt_ = !(k + 1 >= g + 1 && k + 1 <= end_k);
         bif.bus_rdy_  = !(k + 1 >= g + 2 + w && k + 1 <= end_k);
         bif.bus_rd_data = bif.bus_rdy_ ? $urandom : rd;
      end
   endtask

   task automatic test_reset();
      #3 reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({core_busy, bif.bus_req_, bif.bus_as_, core_done, core_err} !== 5'b01100) begin
         n_errors++;
         $display("FAIL reset_ctl got %b expected 01100",
                  {core_busy, bif.bus_req_, bif.bus_as_, core_done, core_err});
      end
      n_checks++;
      if ({bif.bus_rw, bif.bus_addr, bif.bus_wr_data, core_rd_data} !== {1'b1, 30'd0, 32'd0, 32'd0}) begin
         n_errors++;
         $display("FAIL reset_data got rw=%b addr=%h wd=%h rd=%h expected 1/0/0/0",
                  bif.bus_rw, bif.bus_addr, bif.bus_wr_data, core_rd_data);
      end
      reset = 1'b1;
      exp_rd = '0;
      @(negedge clk);
   endtask

   task automatic test_read_immediate();
      run_txn(1'b1, 30'h0000010, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0);
   endtask

   task automatic test_write_wait();
      run_txn(1'b0, 30'h0001234, 32'h12345678, 32'h0BADF00D, 0, 4, 0, 1'b0);
   endtask

   task automatic test_grant_delay();
      run_txn(1'b1, 30'h2AAAAAA, 32'h0, 32'hA5A5_0F0F, 5, 0, 0, 1'b0);
   endtask

   task automatic test_flush();
      run_txn(1'b1, 30'h0000020, 32'h0, 32'h11111111, 5, 0, 2, 1'b0); // abort in REQ
      run_txn(1'b1, 30'h0000030, 32'h0, 32'h22222222, 0, 3, 3, 1'b0); // ignored in WAIT
      run_txn(1'b1, 30'h0000040, 32'h0, 32'h33333333, 2, 1, 3, 1'b0); // with grant
   endtask

   task automatic test_timeout();
      run_txn(1'b1, 30'h0000050, 32'h0, 32'h44444444, 1, 8, 0, 1'b0);   // last chance
      run_txn(1'b1, 30'h0000060, 32'h0, 32'h55555555, 1, 9, 0, 1'b0);   // one late
      run_txn(1'b0, 30'h0000070, 32'h1, 32'h66666666, 0, 1000, 0, 1'b0); // never
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 30'h0000080, 32'h0, 32'h77777777, 0, 0, 0, 1'b1);
      run_txn(1'b1, 30'h0000090, 32'h0, 32'h88888888, 0, 100, 0, 1'b1);
      run_txn(1'b0, 30'h00000A0, 32'h99999999, 32'h0, 1, 2, 0, 1'b0);
   endtask

   task automatic test_random();
      int g, w, fe;
      bit hold;
      for (int i = 0; i < 40; i++) begin
         g  = $urandom_range(0, 4);
         w  = $urandom_range(0, 10);
         fe = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         hold = !(fe >= 1 && fe <= g) && (i != 39) && ($urandom_range(0, 1) == 1);
         run_txn(1'($urandom), 30'($urandom), $urandom, $urandom, g, w, fe, hold);
      end
   endtask

   task automatic test_reset_mid();
      run_txn(1'b1, 30'h00000B0, 32'h0, 32'hCAFEF00D, 0, 0, 0, 1'b0);
      core_rw = 1'b0; core_addr = 30'h00000C0; core_wr_data = 32'hFEEDFACE;
      core_as_ = 1'b0; bif.bus_grnt_ = 1'b0; bif.bus_rdy_ = 1'b1;
      @(posedge clk);
      @(negedge clk);
      core_as_ = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({core_busy, bif.bus_req_} !== 2'b10) begin
         n_errors++;
         $display("FAIL mid_busy {busy,req_} got %b expected 10", {core_busy, bif.bus_req_});
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({core_busy, bif.bus_req_, bif.bus_as_, core_done, core_err} !== 5'b01100) begin
         n_errors++;
         $display("FAIL mid_reset_ctl got %b expected 01100",
                  {core_busy, bif.bus_req_, bif.bus_as_, core_done, core_err});
      end
      n_checks++;
      if ({bif.bus_rw, bif.bus_addr, bif.bus_wr_data, core_rd_data} !== {1'b1, 30'd0, 32'd0, 32'd0}) begin
         n_errors++;
         $display("FAIL mid_reset_data got rw=%b addr=%h wd=%h rd=%h expected 1/0/0/0",
                  bif.bus_rw, bif.bus_addr, bif.bus_wr_data, core_rd_data);
      end
      bif.bus_grnt_ = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      exp_rd = '0;
      @(negedge clk);
      run_txn(1'b1, 30'h00000D0, 32'h0, 32'h13579BDF, 1, 2, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_read_immediate();
      test_write_wait();
      test_grant_delay();
      test_flush();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
